// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled, majority-voting UART receiver with ready/valid byte output
//
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit between data and stop).
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active high
//   uart_rx    asynchronous serial line, idle high
//   data       received byte, stable while valid
//   valid      byte available
//   ready      consumer accepts when valid && ready
//   frame_err  1-cycle pulse: a stop bit voted 0, frame dropped
//   overrun    1-cycle pulse: frame completed while valid && !ready, new byte dropped
//   parity_err 1-cycle pulse: parity mismatch, frame dropped (tied 0 without the macro)
module uart_rx_oversampled #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_V0     = OS_W'(M - 1);
  localparam logic [OS_W-1:0]  OS_V1     = OS_W'(M);
  localparam logic [OS_W-1:0]  OS_V2     = OS_W'(M + 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic                  rx_meta, rx_sync;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;

  state_t                state_q, state_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            samp_q, samp_d;
  logic                  vote, at_vote, os_end;
  logic                  deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                  parity_q, parity_d;
  logic                  perr_set;
`endif

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Two earlier samples are held in samp_q; the third is the live synced line at M+1.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);
  assign at_vote = (os_q == OS_V2);
  assign os_end  = (os_q == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      os_q     <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      samp_q   <= '0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      os_q     <= os_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      samp_q   <= samp_d;
`ifdef UART_RX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    samp_d   = samp_q;
    deliver  = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
    perr_set = 1'b0;
`endif
    if (tick) begin
      if (os_q == OS_V0) samp_d[0] = rx_sync;
      if (os_q == OS_V1) samp_d[1] = rx_sync;
      os_d = os_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          os_d = '0;
          if (!rx_sync) state_d = S_START;
        end
        S_START: begin
          if (at_vote && vote) begin
            // Start bit did not hold low through mid-bit: treat as noise.
            state_d = S_IDLE;
            os_d    = '0;
          end else if (os_end) begin
            state_d = S_DATA;
            os_d    = '0;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          if (os_end) begin
            os_d = '0;
            if (bit_q == BIT_LAST) begin
              stop_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_vote) parity_d = vote;
          if (os_end) begin
            os_d    = '0;
            stop_d  = 1'b0;
            state_d = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (at_vote && !vote) begin
            ferr_set = 1'b1;
            state_d  = S_IDLE;
            os_d     = '0;
          end else if (at_vote && (stop_q == STOP_LAST)) begin
            // Re-arm at the last stop vote so a back-to-back start edge is not missed.
            state_d = S_IDLE;
            os_d    = '0;
`ifdef UART_RX_PARITY_EN
            if ((^shift_q) ^ parity_q) perr_set = 1'b1;
            else                      deliver  = 1'b1;
`else
            deliver = 1'b1;
`endif
          end else if (os_end) begin
            os_d   = '0;
            stop_d = stop_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          os_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift_q;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_set;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - randomized self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

  localparam int CLK_FREQ   = 8000000;
  localparam int BAUD_RATE  = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int DW         = 8;
  localparam int STOP_BITS  = 1;
  localparam int DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT        = DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Ticks from one break re-trigger to the next: start + data (+parity) + stop up to its vote + 1.
  localparam int BRK_P = OVERSAMPLE * (1 + DW + PB) + OVERSAMPLE / 2 + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid, frame_err, overrun, parity_err;
`ifdef UART_RX_PARITY_EN
  logic          par_flip = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  logic [DW-1:0] acc_q[$];

  uart_rx_oversampled #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
    .DATA_WIDTH(DW), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (parity_err) perr_cnt++;
    if (valid && ready) acc_q.push_back(data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    for (int s = 0; s < STOP_BITS; s++) drive_bit(stop_val);
    uart_rx = 1'b1;
  endtask

  task automatic flush();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid, frame_err, overrun, parity_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got=%b exp=0000", {valid, frame_err, overrun, parity_err});
    end
    checks++;
    if (data !== '0) begin failures++; $display("FAIL reset_data: got=%h exp=00", data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * BIT);
  endtask

  task automatic test_basic();
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    ready = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h55) begin
      failures++; $display("FAIL basic_rx: got valid=%b data=%h exp valid=1 data=55", valid, data);
    end
    idle(300);
    checks++;
    if (valid !== 1'b1 || data !== 8'h55) begin
      failures++; $display("FAIL basic_hold: got valid=%b data=%h exp valid=1 data=55", valid, data);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL basic_accept: got valid=%b exp 0", valid); end
    #1;
    ready = 1'b0;
    checks++;
    if (ferr_cnt != f0 || ovr_cnt != o0) begin
      failures++; $display("FAIL basic_pulses: got ferr=%0d ovr=%0d exp 0 0", ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_false_start();
    int f0, o0, p0;
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    idle(2 * BIT);
    checks++;
    if (valid !== 1'b0 || ferr_cnt != f0 || ovr_cnt != o0 || perr_cnt != p0) begin
      failures++;
      $display("FAIL glitch: got valid=%b ferr=%0d ovr=%0d perr=%0d exp all 0",
               valid, ferr_cnt - f0, ovr_cnt - o0, perr_cnt - p0);
    end
    send_frame(8'h5A, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h5A) begin
      failures++; $display("FAIL glitch_after: got valid=%b data=%h exp valid=1 data=5a", valid, data);
    end
    flush();
  endtask

  task automatic test_frame_error();
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA3, 1'b0);
    idle(2 * BIT);
    checks++;
    if (ferr_cnt - f0 != 1 || valid !== 1'b0 || ovr_cnt != o0) begin
      failures++;
      $display("FAIL frame_err: got ferr_cycles=%0d valid=%b ovr=%0d exp 1 0 0", ferr_cnt - f0, valid, ovr_cnt - o0);
    end
    send_frame(8'h41, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h41 || ferr_cnt - f0 != 1) begin
      failures++;
      $display("FAIL frame_err_next: got valid=%b data=%h ferr=%0d exp 1 41 1", valid, data, ferr_cnt - f0);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ovr_cnt;
    ready = 1'b0;
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h41 || ovr_cnt - o0 != 1) begin
      failures++;
      $display("FAIL overrun: got valid=%b data=%h ovr_cycles=%0d exp 1 41 1", valid, data, ovr_cnt - o0);
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL overrun_accept: got valid=%b exp 0", valid); end
    #1;
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] b;
    int f0, o0, p0;
    b = 8'h3C;
    send_frame(8'h11, 1'b1);
    idle(20);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rx = b[4];
    repeat (BIT / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || data !== '0) begin
      failures++; $display("FAIL rst_async: got valid=%b data=%h exp 0 00", valid, data);
    end
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2 * BIT);
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL rst_quiet: got valid=%b exp 0", valid); end
    send_frame(8'h7E, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h7E || ferr_cnt != f0 || ovr_cnt != o0 || perr_cnt != p0) begin
      failures++;
      $display("FAIL rst_next: got valid=%b data=%h pulses=%0d exp 1 7e 0", valid, data,
               (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0));
    end
    flush();
  endtask

  task automatic test_break();
    int f0, o0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    // Release after the third re-triggered frame error, before the fourth start's vote.
    repeat (3 * BRK_P * DIV + 12) @(posedge clk);
    #1;
    idle(3 * BIT);
    checks++;
    if (ferr_cnt - f0 != 3 || valid !== 1'b0 || ovr_cnt != o0) begin
      failures++;
      $display("FAIL break: got ferr=%0d valid=%b ovr=%0d exp 3 0 0", ferr_cnt - f0, valid, ovr_cnt - o0);
    end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int p0;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1);
    idle(20);
    checks++;
    if (valid !== 1'b1 || data !== 8'h07 || perr_cnt != p0) begin
      failures++; $display("FAIL parity_ok: got valid=%b data=%h perr=%0d exp 1 07 0", valid, data, perr_cnt - p0);
    end
    flush();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(20);
    checks++;
    if (valid !== 1'b0 || perr_cnt - p0 != 1) begin
      failures++; $display("FAIL parity_bad: got valid=%b perr=%0d exp 0 1", valid, perr_cnt - p0);
    end
`else
    checks++;
    if (perr_cnt != 0) begin failures++; $display("FAIL parity_tied: got perr=%0d exp 0", perr_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic          pend;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] b;
    logic          r, bad;
    int            f0, o0, exp_f, exp_o, gap;
    acc_q.delete();
    pend = 1'b0; pend_data = '0;
    f0 = ferr_cnt; o0 = ovr_cnt; exp_f = 0; exp_o = 0;
    for (int n = 0; n < 24; n++) begin
      b   = DW'($urandom);
      r   = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 4) == 0);
      ready = r;
      if (r && pend) begin exp_q.push_back(pend_data); pend = 1'b0; end
      send_frame(b, !bad);
      if (bad) begin
        exp_f++;
      end else if (r) begin
        exp_q.push_back(b);
      end else if (pend) begin
        exp_o++;
      end else begin
        pend = 1'b1; pend_data = b;
      end
      gap = bad ? 2 * BIT : (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40)));
      idle(gap);
      checks++;
      if (valid !== pend || (pend && data !== pend_data)) begin
        failures++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h exp valid=%b data=%h", n, valid, data, pend, pend_data);
      end
      checks++;
      if (ferr_cnt - f0 != exp_f || ovr_cnt - o0 != exp_o) begin
        failures++;
        $display("FAIL rand_pulses[%0d]: got ferr=%0d ovr=%0d exp %0d %0d", n, ferr_cnt - f0, ovr_cnt - o0, exp_f, exp_o);
      end
    end
    ready = 1'b1;
    if (pend) exp_q.push_back(pend_data);
    idle(4);
    ready = 1'b0;
    checks++;
    if (acc_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count: got %0d accepted exp %0d", acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_byte[%0d]: got %h exp %h", i, acc_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_parity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
